unisim_sram_b_11abits_arb: RTL and testbench
============================================

Name: unisim_sram_b_11abits_arb

Overview:
Round-robin arbiter that shares one 2048x8 1w:1r SRAM wrapper (unisim_sram_b_11abits) among NREQ clients. Clients request through independent write and read channels. The block drives the memory's CE0/A0/D0/WE0/WEM0 and CE1/A1 ports, suppresses same-address write/read collisions, and returns read data tagged with the requester index. It sits between accelerator PLM clients and the memory instance.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 1, width of requester index; must equal max(1, ceil(log2(NREQ)))

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  reset, asynchronous, active-high
wr_req  in  NREQ  per-client write request
wr_addr  in  NREQ*11  per-client write address; client i at [11i+10:11i]
wr_data  in  NREQ*8  per-client write data
wr_mask  in  NREQ*8  per-client bit write mask
wr_gnt  out  NREQ  one-hot write grant; the write is performed in the granting cycle
rd_req  in  NREQ  per-client read request
rd_addr  in  NREQ*11  per-client read address
rd_gnt  out  NREQ  one-hot read grant; the address is accepted in the granting cycle
rd_valid  out  1  read response valid, one cycle after the grant
rd_id  out  IDW  index of the client that owns the response
rd_data  out  8  response data
CE0  out  1  memory write-port enable
A0  out  11  memory write address
D0  out  8  memory write data
WE0  out  1  memory write enable
WEM0  out  8  memory write mask
CE1  out  1  memory read-port enable
A1  out  11  memory read address
Q1  in  8  memory read data, valid one cycle after CE1

Behaviour:
- Reset (asynchronous assert, synchronous release): wr_ptr=0, rd_ptr=0, rd_valid=0, rd_id=0. During reset all grants=0, CE0=WE0=CE1=0, and A0/D0/WEM0/A1=0.
- Write arbitration (combinational):
  - Search starts at client wr_ptr and wraps modulo NREQ; the first client with wr_req=1 is the winner w.
  - wr_gnt[w]=1, CE0=1, WE0=1, A0/D0/WEM0 = client w's fields.
  - With no write request: wr_gnt=0, CE0=WE0=0, and A0/D0/WEM0=0.
- Read arbitration: the same search from rd_ptr over rd_req selects candidate r.
- Collision rule: if a write is granted and rd_addr[r]==A0, the read is withheld for that cycle (rd_gnt=0, CE1=0, A1=0, rd_ptr unchanged). The write always has priority. A read to a different address proceeds in the same cycle.
- Read grant: rd_gnt[r]=1, CE1=1, A1=rd_addr[r].
- Pointer update on the clock edge:
  - wr_ptr <= (w+1) mod NREQ when a write was granted, else unchanged.
  - rd_ptr <= (r+1) mod NREQ when a read was granted, else unchanged.
- Response pipeline:
  - rd_valid <= CE1, and rd_id <= r when CE1 (holds otherwise).
  - rd_data = Q1 when rd_valid=1, else 8'h00.
  - Fixed latency of 1 cycle from grant to data.
- Requests are level signals. A client holds its request until granted. A client deasserting before its grant is legal and causes no grant.
- A client may hold wr_req and rd_req together. Both may be granted in the same cycle when the addresses differ.
- Simultaneous reset during an in-flight read: rd_valid clears immediately and the response is dropped.
- Fairness: with all clients requesting continuously, each client is granted exactly once every NREQ cycles per channel.
- Simulation-only check: never CE0&WE0&CE1 with A0==A1. Violation triggers $display and $finish.

Test Plan:
- Reset, then client0 writes addr 0x005 data 0xA5 mask 0xFF; next cycle client1 reads 0x005 -> wr_gnt=01, then rd_gnt=10; following cycle rd_valid=1, rd_id=1, rd_data=0xA5.
- Both clients assert wr_req continuously for 6 cycles with distinct addresses -> wr_gnt sequence 01,10,01,10,01,10.
- Same cycle: client0 writes 0x100 and client1 reads 0x100 -> rd_gnt=00 and CE1=0. Next cycle, with the write gone, rd_gnt=10; then rd_data equals the newly written byte.
- Same cycle: write 0x010 and read 0x011 -> both granted, CE0=CE1=1, no assertion fires.
- Masked write 0xFF to 0x020 with mask 0x0F over prior 0x00 -> a later read returns 0x0F.
- Assert RST while rd_valid is pending -> rd_valid=0 immediately. After release, pointers restart at 0 and the first grant goes to client0 when both clients request.

Source files
------------

// File: rtl/unisim_sram_b_11abits_arb.sv
// Round-robin arbiter sharing one 2048x8 1w:1r SRAM among NREQ clients.
// Writes win same-address collisions; read data returns one cycle after grant, tagged by client.
module unisim_sram_b_11abits_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   wr_req,
  input  logic [NREQ*11-1:0] wr_addr,
  input  logic [NREQ*8-1:0] wr_data,
  input  logic [NREQ*8-1:0] wr_mask,
  output logic [NREQ-1:0]   wr_gnt,
  input  logic [NREQ-1:0]   rd_req,
  input  logic [NREQ*11-1:0] rd_addr,
  output logic [NREQ-1:0]   rd_gnt,
  output logic              rd_valid,
  output logic [IDW-1:0]    rd_id,
  output logic [7:0]        rd_data,
  output logic              CE0,
  output logic [10:0]       A0,
  output logic [7:0]        D0,
  output logic              WE0,
  output logic [7:0]        WEM0,
  output logic              CE1,
  output logic [10:0]       A1,
  input  logic [7:0]        Q1
);

  logic [IDW-1:0] r_wr_ptr;
  logic [IDW-1:0] r_rd_ptr;
  logic           r_rd_valid;
  logic [IDW-1:0] r_rd_id;

  logic           w_wr_hit;
  logic [IDW-1:0] w_wr_idx;
  logic           w_rd_hit;
  logic [IDW-1:0] w_rd_idx;
  logic [10:0]    w_wr_addr;
  logic [7:0]     w_wr_data;
  logic [7:0]     w_wr_mask;
  logic [10:0]    w_rd_addr;
  logic           w_wr_grant;
  logic           w_rd_block;
  logic           w_rd_grant;

  // Returns {hit, index}; descending scan so the lowest offset from ptr wins.
  function automatic logic [IDW:0] f_pick(input logic [NREQ-1:0] req,
                                          input logic [IDW-1:0]  ptr);
    logic [IDW:0]   res;
    int unsigned    c;
    logic [IDW-1:0] cidx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c    = (int'(ptr) + k) % NREQ;
      cidx = IDW'(c);
      if (req[cidx]) res = {1'b1, cidx};
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] f_inc(input logic [IDW-1:0] idx);
    if (idx == IDW'(NREQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  always_comb begin
    {w_wr_hit, w_wr_idx} = f_pick(wr_req, r_wr_ptr);
    {w_rd_hit, w_rd_idx} = f_pick(rd_req, r_rd_ptr);
  end

  assign w_wr_addr = wr_addr[w_wr_idx*11 +: 11];
  assign w_wr_data = wr_data[w_wr_idx*8 +: 8];
  assign w_wr_mask = wr_mask[w_wr_idx*8 +: 8];
  assign w_rd_addr = rd_addr[w_rd_idx*11 +: 11];

  assign w_wr_grant = !RST && w_wr_hit;
  assign w_rd_block = w_wr_grant && (w_rd_addr == w_wr_addr);
  assign w_rd_grant = !RST && w_rd_hit && !w_rd_block;

  always_comb begin
    wr_gnt = '0;
    CE0    = 1'b0;
    WE0    = 1'b0;
    A0     = '0;
    D0     = '0;
    WEM0   = '0;
    if (w_wr_grant) begin
      wr_gnt[w_wr_idx] = 1'b1;
      CE0              = 1'b1;
      WE0              = 1'b1;
      A0               = w_wr_addr;
      D0               = w_wr_data;
      WEM0             = w_wr_mask;
    end
  end

  always_comb begin
    rd_gnt = '0;
    CE1    = 1'b0;
    A1     = '0;
    if (w_rd_grant) begin
      rd_gnt[w_rd_idx] = 1'b1;
      CE1              = 1'b1;
      A1               = w_rd_addr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= '0;
    end else begin
      if (w_wr_grant) r_wr_ptr <= f_inc(w_wr_idx);
      if (w_rd_grant) begin
        r_rd_ptr <= f_inc(w_rd_idx);
        r_rd_id  <= w_rd_idx;
      end
      r_rd_valid <= w_rd_grant;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_id    = r_rd_id;
  assign rd_data  = r_rd_valid ? Q1 : 8'h00;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (!RST && CE0 && WE0 && CE1 && (A0 == A1)) begin
      $display("unisim_sram_b_11abits_arb: write/read same-address collision at %h", A0);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_unisim_sram_b_11abits_arb.sv
// Directed bench for unisim_sram_b_11abits_arb with a behavioural 2048x8 masked SRAM.
module tb_unisim_sram_b_11abits_arb;
  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   wr_req;
  logic [NREQ*11-1:0] wr_addr;
  logic [NREQ*8-1:0] wr_data;
  logic [NREQ*8-1:0] wr_mask;
  logic [NREQ-1:0]   wr_gnt;
  logic [NREQ-1:0]   rd_req;
  logic [NREQ*11-1:0] rd_addr;
  logic [NREQ-1:0]   rd_gnt;
  logic              rd_valid;
  logic [IDW-1:0]    rd_id;
  logic [7:0]        rd_data;
  logic              CE0;
  logic [10:0]       A0;
  logic [7:0]        D0;
  logic              WE0;
  logic [7:0]        WEM0;
  logic              CE1;
  logic [10:0]       A1;
  logic [7:0]        Q1;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:2047];

  unisim_sram_b_11abits_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: masked write, one-cycle registered read.
  always @(posedge CLK) begin
    if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
    if (CE1) Q1 <= mem[A1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_req  = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    rd_req  = '0;
    rd_addr = '0;
  endtask

  task automatic set_wr(input int i, input logic [10:0] a, input logic [7:0] d,
                        input logic [7:0] m);
    wr_req[i]          = 1'b1;
    wr_addr[11*i +: 11] = a;
    wr_data[8*i +: 8]   = d;
    wr_mask[8*i +: 8]   = m;
  endtask

  task automatic set_rd(input int i, input logic [10:0] a);
    rd_req[i]           = 1'b1;
    rd_addr[11*i +: 11] = a;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    Q1  = 8'h00;
    RST = 1'b1;
    clr();
    wr_req = 2'b11;
    rd_req = 2'b11;
    #1;
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_ce0", CE0, 0);
    chk("rst_we0", WE0, 0);
    chk("rst_ce1", CE1, 0);
    chk("rst_a0", A0, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);

    @(negedge CLK);
    RST = 1'b0;
    clr();

    // client0 writes 0x005
    @(negedge CLK);
    set_wr(0, 11'h005, 8'hA5, 8'hFF);
    #1;
    chk("w1_wr_gnt", wr_gnt, 2'b01);
    chk("w1_ce0", CE0, 1);
    chk("w1_we0", WE0, 1);
    chk("w1_a0", A0, 11'h005);
    chk("w1_d0", D0, 8'hA5);
    chk("w1_wem0", WEM0, 8'hFF);
    chk("w1_ce1", CE1, 0);

    // client1 reads 0x005
    @(negedge CLK);
    clr();
    set_rd(1, 11'h005);
    #1;
    chk("r1_rd_gnt", rd_gnt, 2'b10);
    chk("r1_ce1", CE1, 1);
    chk("r1_a1", A1, 11'h005);
    chk("r1_ce0", CE0, 0);
    chk("r1_a0", A0, 0);

    @(negedge CLK);
    clr();
    chk("r1_valid", rd_valid, 1);
    chk("r1_id", rd_id, 1);
    chk("r1_data", rd_data, 8'hA5);

    // client1 writes top address; wr_ptr returns to 0
    @(negedge CLK);
    chk("idle_valid", rd_valid, 0);
    chk("idle_data", rd_data, 0);
    set_wr(1, 11'h7FF, 8'h3C, 8'hFF);
    #1;
    chk("w2_wr_gnt", wr_gnt, 2'b10);
    chk("w2_a0", A0, 11'h7FF);

    // write fairness: both clients continuously
    @(negedge CLK);
    clr();
    set_wr(0, 11'h040, 8'h11, 8'hFF);
    set_wr(1, 11'h041, 8'h22, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge CLK);
      #1;
      chk("fair_wr_gnt", wr_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("fair_a0", A0, (k % 2 == 0) ? 11'h040 : 11'h041);
    end

    // read fairness: rd_ptr is 0
    @(negedge CLK);
    clr();
    set_rd(0, 11'h040);
    set_rd(1, 11'h041);
    #1;
    chk("fr0_rd_gnt", rd_gnt, 2'b01);
    chk("fr0_a1", A1, 11'h040);
    @(negedge CLK);
    chk("fr0_id", rd_id, 0);
    chk("fr0_data", rd_data, 8'h11);
    #1;
    chk("fr1_rd_gnt", rd_gnt, 2'b10);
    chk("fr1_a1", A1, 11'h041);
    @(negedge CLK);
    clr();
    chk("fr1_id", rd_id, 1);
    chk("fr1_data", rd_data, 8'h22);

    // collision: write wins, read withheld
    @(negedge CLK);
    set_wr(0, 11'h100, 8'h5A, 8'hFF);
    set_rd(1, 11'h100);
    #1;
    chk("col_wr_gnt", wr_gnt, 2'b01);
    chk("col_rd_gnt", rd_gnt, 2'b00);
    chk("col_ce1", CE1, 0);
    chk("col_a1", A1, 0);
    @(negedge CLK);
    clr();
    set_rd(1, 11'h100);
    chk("col_no_valid", rd_valid, 0);
    #1;
    chk("col_retry_gnt", rd_gnt, 2'b10);
    chk("col_retry_a1", A1, 11'h100);
    @(negedge CLK);
    clr();
    chk("col_valid", rd_valid, 1);
    chk("col_id", rd_id, 1);
    chk("col_data", rd_data, 8'h5A);

    // parallel write and read to different addresses
    @(negedge CLK);
    set_wr(0, 11'h010, 8'h77, 8'hFF);
    set_rd(1, 11'h011);
    #1;
    chk("par_wr_gnt", wr_gnt, 2'b01);
    chk("par_rd_gnt", rd_gnt, 2'b10);
    chk("par_ce0", CE0, 1);
    chk("par_ce1", CE1, 1);
    chk("par_a1", A1, 11'h011);
    @(negedge CLK);
    clr();
    chk("par_valid", rd_valid, 1);
    chk("par_id", rd_id, 1);
    chk("par_data", rd_data, 8'h00);

    // masked write then read back
    @(negedge CLK);
    set_wr(0, 11'h020, 8'hFF, 8'h0F);
    #1;
    chk("msk_wem0", WEM0, 8'h0F);
    @(negedge CLK);
    clr();
    set_rd(0, 11'h020);
    #1;
    chk("msk_rd_gnt", rd_gnt, 2'b01);
    @(negedge CLK);
    clr();
    chk("msk_id", rd_id, 0);
    chk("msk_data", rd_data, 8'h0F);

    // reset while a response is pending
    @(negedge CLK);
    set_rd(1, 11'h005);
    #1;
    chk("rr_rd_gnt", rd_gnt, 2'b10);
    @(negedge CLK);
    chk("rr_valid_pre", rd_valid, 1);
    RST = 1'b1;
    #1;
    chk("rr_valid_rst", rd_valid, 0);
    chk("rr_data_rst", rd_data, 0);
    chk("rr_id_rst", rd_id, 0);
    chk("rr_ce1_rst", CE1, 0);
    @(negedge CLK);
    RST = 1'b0;
    clr();
    set_wr(0, 11'h030, 8'h01, 8'hFF);
    set_wr(1, 11'h031, 8'h02, 8'hFF);
    set_rd(0, 11'h005);
    set_rd(1, 11'h7FF);
    #1;
    chk("pr_wr_gnt0", wr_gnt, 2'b01);
    chk("pr_rd_gnt0", rd_gnt, 2'b01);
    @(negedge CLK);
    chk("pr_valid0", rd_valid, 1);
    chk("pr_id0", rd_id, 0);
    chk("pr_data0", rd_data, 8'hA5);
    #1;
    chk("pr_wr_gnt1", wr_gnt, 2'b10);
    chk("pr_rd_gnt1", rd_gnt, 2'b10);
    @(negedge CLK);
    clr();
    chk("pr_id1", rd_id, 1);
    chk("pr_data1", rd_data, 8'h3C);

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
